// File: rtl/mem_access_sequencer_pkg.sv
// Shared constants for the memory access sequencer: FSM state codes,
// controller read/write op codes and the serial-port addresses.
package mem_access_sequencer_pkg;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_FETCH = 2'b01;
    localparam logic [1:0] S_DATA  = 2'b10;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_W1   = 2'b01;
    localparam logic [1:0] MEM_W2   = 2'b10;

    localparam logic [15:0] SERIAL_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] SERIAL_STAT_ADDR = 16'hBF01;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Pipeline-side requests and controller-side access bundle of the sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface mem_access_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [1:0]        mem_read;
    logic [1:0]        mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] ctrl_rdata;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic [1:0]        ctrl_memRead;
    logic [1:0]        ctrl_memWrite;
    logic [DATA_W-1:0] if_instr;
    logic              if_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              stall;
    logic              illegal;

    modport master (
        input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, ctrl_rdata,
        output ctrl_addr, ctrl_wdata, ctrl_memRead, ctrl_memWrite,
        output if_instr, if_valid, mem_rdata, mem_done, stall, illegal
    );

    modport slave (
        output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, ctrl_rdata,
        input  ctrl_addr, ctrl_wdata, ctrl_memRead, ctrl_memWrite,
        input  if_instr, if_valid, mem_rdata, mem_done, stall, illegal
    );

endinterface

// File: rtl/mem_access_sequencer_req_latch.sv
// Single-entry pending data-request register: loads on accept, drops valid on
// clear (the DATA slot exit). Fields are held after clear.
module mem_access_sequencer_req_latch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              accept,
    input  logic              clear,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [1:0]        in_rd,
    input  logic [1:0]        in_wr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        rd,
    output logic [1:0]        wr
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            rd    <= '0;
            wr    <= '0;
        end else if (accept) begin
            valid <= 1'b1;
            addr  <= in_addr;
            wdata <= in_wdata;
            rd    <= in_rd;
            wr    <= in_wr;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Serialises IF fetches and MEM data accesses onto the shared memory
// controller, one access per cycle, and raises the structural-hazard stall.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int         ADDR_W   = 16,
    parameter int         DATA_W   = 16,
    parameter logic [1:0] FETCH_RD = MEM_W1
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_access_sequencer_if.master bus
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              rd_req;
    logic              wr_req;
    logic              accept;
    logic              busy;
    logic              done_q;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    logic [1:0]        pend_rd;
    logic [1:0]        pend_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_rd;
    logic [1:0]        sel_wr;

    assign rd_req = (bus.mem_read != MEM_NONE);
    assign wr_req = (bus.mem_write != MEM_NONE);
    // The MEM stage stays frozen from accept through the mem_done cycle.
    assign busy      = pend_valid | done_q;
    assign accept    = RST & (rd_req ^ wr_req) & ~busy;
    assign bus.stall = accept | busy;
    assign bus.mem_done = done_q;

    mem_access_sequencer_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_latch (
        .CLK      (CLK),
        .RST      (RST),
        .accept   (accept),
        .clear    (state == S_DATA),
        .in_addr  (bus.mem_addr),
        .in_wdata (bus.mem_wdata),
        .in_rd    (bus.mem_read),
        .in_wr    (bus.mem_write),
        .valid    (pend_valid),
        .addr     (pend_addr),
        .wdata    (pend_wdata),
        .rd       (pend_rd),
        .wr       (pend_wr)
    );

    // A request accepted this cycle goes straight to the next DATA slot.
    assign sel_addr  = accept ? bus.mem_addr  : pend_addr;
    assign sel_wdata = accept ? bus.mem_wdata : pend_wdata;
    assign sel_rd    = accept ? bus.mem_read  : pend_rd;
    assign sel_wr    = accept ? bus.mem_write : pend_wr;

    always_comb begin
        state_nxt = S_IDLE;
        if (state == S_DATA)
            state_nxt = bus.if_req ? S_FETCH : S_IDLE;
        else if (accept || pend_valid)
            state_nxt = S_DATA;
        else if (bus.if_req)
            state_nxt = S_FETCH;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state             <= S_IDLE;
            bus.ctrl_addr     <= '0;
            bus.ctrl_wdata    <= '0;
            bus.ctrl_memRead  <= MEM_NONE;
            bus.ctrl_memWrite <= MEM_NONE;
            bus.if_instr      <= '0;
            bus.if_valid      <= 1'b0;
            bus.mem_rdata     <= '0;
            done_q            <= 1'b0;
            bus.illegal       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state_nxt)
                S_DATA: begin
                    bus.ctrl_addr     <= sel_addr;
                    bus.ctrl_wdata    <= sel_wdata;
                    bus.ctrl_memRead  <= sel_rd;
                    bus.ctrl_memWrite <= sel_wr;
                end
                S_FETCH: begin
                    bus.ctrl_addr     <= bus.if_addr;
                    bus.ctrl_memRead  <= FETCH_RD;
                    bus.ctrl_memWrite <= MEM_NONE;
                end
                default: begin
                    bus.ctrl_memRead  <= MEM_NONE;
                    bus.ctrl_memWrite <= MEM_NONE;
                end
            endcase

            bus.if_valid <= (state == S_FETCH);
            if (state == S_FETCH)
                bus.if_instr <= bus.ctrl_rdata;

            done_q <= (state == S_DATA);
            if (state == S_DATA && bus.ctrl_memRead != MEM_NONE)
                bus.mem_rdata <= bus.ctrl_rdata;

            if (rd_req && wr_req)
                bus.illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a slot-level reference model.
module tb_mem_access_sequencer;
    import mem_access_sequencer_pkg::*;

    localparam int K_IDLE  = 0;
    localparam int K_FETCH = 1;
    localparam int K_DATA  = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  rd;
        logic [1:0]  wr;
    } slot_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    bit   run = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    mem_access_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_access_sequencer #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .FETCH_RD (2'b01)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: which access owns the memory slot this cycle,
    // at most one queued data request, and the results of the last slot.
    slot_t       cur;
    slot_t       q[$];
    logic        m_ifv, m_done, m_ill;
    logic [15:0] m_instr, m_rdata;

    function automatic bit m_accept();
        bit rq = (bus.mem_read != 2'b00);
        bit wq = (bus.mem_write != 2'b00);
        bit frozen = (q.size() != 0) || (cur.kind == K_DATA) || m_done;
        return RST && (rq ^ wq) && !frozen;
    endfunction

    function automatic logic m_stall();
        if (!RST) return 1'b0;
        return m_accept() || (q.size() != 0) || (cur.kind == K_DATA) || m_done;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q.delete();
            cur     = '{kind: K_IDLE, addr: '0, wdata: '0, rd: '0, wr: '0};
            m_ifv   = 1'b0;
            m_done  = 1'b0;
            m_ill   = 1'b0;
            m_instr = '0;
            m_rdata = '0;
        end else begin
            automatic bit acc = m_accept();
            if (bus.mem_read != 2'b00 && bus.mem_write != 2'b00) m_ill = 1'b1;
            m_ifv = (cur.kind == K_FETCH);
            if (m_ifv) m_instr = bus.ctrl_rdata;
            m_done = (cur.kind == K_DATA);
            if (m_done && cur.rd != 2'b00) m_rdata = bus.ctrl_rdata;
            if (acc)
                q.push_back('{kind: K_DATA, addr: bus.mem_addr, wdata: bus.mem_wdata,
                              rd: bus.mem_read, wr: bus.mem_write});
            if (q.size() != 0)
                cur = q.pop_front();
            else if (bus.if_req)
                cur = '{kind: K_FETCH, addr: bus.if_addr, wdata: '0, rd: '0, wr: '0};
            else
                cur = '{kind: K_IDLE, addr: '0, wdata: '0, rd: '0, wr: '0};
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        #1;
        if (run) begin
            chk("ctrl_memRead", 16'(bus.ctrl_memRead),
                cur.kind == K_FETCH ? 16'h0001 : cur.kind == K_DATA ? 16'(cur.rd) : 16'h0000);
            chk("ctrl_memWrite", 16'(bus.ctrl_memWrite),
                cur.kind == K_DATA ? 16'(cur.wr) : 16'h0000);
            if (cur.kind != K_IDLE) chk("ctrl_addr", bus.ctrl_addr, cur.addr);
            if (cur.kind == K_DATA) chk("ctrl_wdata", bus.ctrl_wdata, cur.wdata);
            chk("if_valid", 16'(bus.if_valid), 16'(m_ifv));
            chk("if_instr", bus.if_instr, m_instr);
            chk("mem_done", 16'(bus.mem_done), 16'(m_done));
            chk("mem_rdata", bus.mem_rdata, m_rdata);
            chk("stall", 16'(bus.stall), 16'(m_stall()));
            chk("illegal", 16'(bus.illegal), 16'(m_ill));
        end
    end

    task automatic idle_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.mem_read   = 2'b00;
        bus.mem_write  = 2'b00;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.ctrl_rdata = '0;
    endtask

    initial begin
        int dones;
        int datas;
        idle_inputs();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        run = 1'b1;

        // Streaming fetch
        @(negedge CLK); bus.if_req = 1'b1; bus.if_addr = 16'h0000;
        @(negedge CLK); bus.ctrl_rdata = 16'h6A01; bus.if_addr = 16'h0001;
        #2 chk("lit fetch0 addr", bus.ctrl_addr, 16'h0000);
        chk("lit fetch0 rd", 16'(bus.ctrl_memRead), 16'h0001);
        chk("lit fetch stall", 16'(bus.stall), 16'h0000);
        @(negedge CLK); bus.ctrl_rdata = 16'h6B02;
        #2 chk("lit instr0", bus.if_instr, 16'h6A01);
        chk("lit ifv0", 16'(bus.if_valid), 16'h0001);
        chk("lit fetch1 addr", bus.ctrl_addr, 16'h0001);

        // Contended read alongside if_req
        @(negedge CLK); bus.mem_read = MEM_W1; bus.mem_addr = 16'h8000;
        #2 chk("lit instr1", bus.if_instr, 16'h6B02);
        chk("lit accept stall", 16'(bus.stall), 16'h0001);
        @(negedge CLK); bus.mem_read = MEM_NONE; bus.ctrl_rdata = 16'h1234;
        #2 chk("lit data addr", bus.ctrl_addr, 16'h8000);
        chk("lit data stall", 16'(bus.stall), 16'h0001);
        @(negedge CLK);
        #2 chk("lit rdata", bus.mem_rdata, 16'h1234);
        chk("lit done", 16'(bus.mem_done), 16'h0001);
        chk("lit fetch after data", 16'(bus.ctrl_memRead), 16'h0001);
        @(negedge CLK); bus.if_req = 1'b0;
        #2 chk("lit stall released", 16'(bus.stall), 16'h0000);

        // Serial write
        @(negedge CLK); bus.mem_write = MEM_W1; bus.mem_addr = SERIAL_DATA_ADDR; bus.mem_wdata = 16'h0041;
        @(negedge CLK); bus.mem_write = MEM_NONE;
        #2 chk("lit ser wr", 16'(bus.ctrl_memWrite), 16'h0001);
        chk("lit ser addr", bus.ctrl_addr, 16'hBF00);
        chk("lit ser wdata", bus.ctrl_wdata, 16'h0041);
        @(negedge CLK);
        #2 chk("lit ser wr off", 16'(bus.ctrl_memWrite), 16'h0000);
        chk("lit ser rdata kept", bus.mem_rdata, 16'h1234);

        // Illegal simultaneous read and write
        @(negedge CLK); bus.mem_read = MEM_W1; bus.mem_write = MEM_W1;
        #2 chk("lit illegal stall", 16'(bus.stall), 16'h0000);
        @(negedge CLK); bus.mem_read = MEM_NONE; bus.mem_write = MEM_NONE;
        #2 chk("lit illegal", 16'(bus.illegal), 16'h0001);
        chk("lit illegal no data", 16'(bus.ctrl_memRead), 16'h0000);

        // Second request while stalled is ignored
        dones = 0;
        datas = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) begin bus.mem_read = MEM_W2; bus.mem_addr = 16'h1111; end
            if (i == 1) bus.mem_addr = 16'h2222;
            if (i == 2) bus.mem_read = MEM_NONE;
            #2;
            if (bus.mem_done) dones++;
            if (bus.ctrl_memRead != MEM_NONE) datas++;
        end
        chk("lit single done", 16'(dones), 16'h0001);
        chk("lit single data", 16'(datas), 16'h0001);

        // Reset in the middle of a fetch
        @(negedge CLK); bus.if_req = 1'b1; bus.if_addr = 16'h0005; bus.ctrl_rdata = 16'h7777;
        @(negedge CLK);
        #3 RST = 1'b0;
        #1 chk("lit rst rd", 16'(bus.ctrl_memRead), 16'h0000);
        chk("lit rst addr", bus.ctrl_addr, 16'h0000);
        chk("lit rst instr", bus.if_instr, 16'h0000);
        chk("lit rst illegal", 16'(bus.illegal), 16'h0000);
        chk("lit rst stall", 16'(bus.stall), 16'h0000);
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK);
        #2 chk("lit rst no ifv", 16'(bus.if_valid), 16'h0000);
        chk("lit rst refetch", 16'(bus.ctrl_memRead), 16'h0001);
        chk("lit rst refetch addr", bus.ctrl_addr, 16'h0005);
        @(negedge CLK);
        #2 chk("lit rst ifv", 16'(bus.if_valid), 16'h0001);
        chk("lit rst instr2", bus.if_instr, 16'h7777);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            if (!RST) RST = 1'b1;
            else if ($urandom_range(0, 199) == 0) RST = 1'b0;
            bus.if_req     = ($urandom_range(0, 3) != 0);
            bus.if_addr    = 16'($urandom);
            bus.mem_addr   = ($urandom_range(0, 7) == 0) ? SERIAL_STAT_ADDR : 16'($urandom);
            bus.mem_wdata  = 16'($urandom);
            bus.ctrl_rdata = 16'($urandom);
            bus.mem_read   = MEM_NONE;
            bus.mem_write  = MEM_NONE;
            case ($urandom_range(0, 39))
                0:       begin bus.mem_read = MEM_W1; bus.mem_write = MEM_W2; end
                1,2,3,4: bus.mem_read  = ($urandom_range(0, 1) != 0) ? MEM_W1 : MEM_W2;
                5,6,7:   bus.mem_write = ($urandom_range(0, 1) != 0) ? MEM_W1 : MEM_W2;
                default: ;
            endcase
        end

        @(negedge CLK);
        idle_inputs();
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
